// File: rtl/lutram_march_if.sv
// Bus between the march sequencer and the LUTRAM under test, plus the
// control/status lines of the sequencer.
interface lutram_march_if #(
    parameter int A_WIDTH = 6,
    parameter int ERR_W   = 8
);
    logic               step;
    logic               start;
    logic [A_WIDTH-1:0] ram_a;
    logic               ram_d;
    logic               ram_we;
    logic               ram_q;
    logic               busy;
    logic               done;
    logic               pass;
    logic [ERR_W-1:0]   err_cnt;
    logic [A_WIDTH-1:0] first_err_addr;
    logic               first_err_pass;

    modport master (
        input  step, start, ram_q,
        output ram_a, ram_d, ram_we, busy, done, pass,
               err_cnt, first_err_addr, first_err_pass
    );

    modport slave (
        output step, start, ram_q,
        input  ram_a, ram_d, ram_we, busy, done, pass,
               err_cnt, first_err_addr, first_err_pass
    );
endinterface

// File: rtl/lutram_march.sv
// Checkerboard march sequencer for a single-port async-read LUTRAM: clear,
// then write/read a checkerboard and its inverse, one RAM access per step.
module lutram_march_ctrl #(
    parameter int A_WIDTH = 6,
    parameter int ERR_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    lutram_march_if.master bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [A_WIDTH-1:0] addr, addr_n;
    logic [A_WIDTH-1:0] fe_addr, fe_addr_n;
    logic               ph, ph_n;
    logic               fe_pass, fe_pass_n;
    logic               seen, seen_n;
    logic [ERR_W-1:0]   err, err_n;
    logic               we, wd;
    logic               exp_bit, last;

    assign exp_bit = addr[0] ^ ph;
    assign last    = &addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr    <= '0;
            ph      <= 1'b0;
            err     <= '0;
            fe_addr <= '0;
            fe_pass <= 1'b0;
            seen    <= 1'b0;
        end else begin
            state   <= state_n;
            addr    <= addr_n;
            ph      <= ph_n;
            err     <= err_n;
            fe_addr <= fe_addr_n;
            fe_pass <= fe_pass_n;
            seen    <= seen_n;
        end
    end

    always_comb begin
        state_n   = state;
        addr_n    = addr;
        ph_n      = ph;
        err_n     = err;
        fe_addr_n = fe_addr;
        fe_pass_n = fe_pass;
        seen_n    = seen;
        we        = 1'b0;
        wd        = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_n   = CLEAR;
                    addr_n    = '0;
                    ph_n      = 1'b0;
                    err_n     = '0;
                    fe_addr_n = '0;
                    fe_pass_n = 1'b0;
                    seen_n    = 1'b0;
                end
            end
            CLEAR: begin
                we = bus.step;
                if (bus.step) begin
                    addr_n = addr + 1'b1;
                    if (last) state_n = WRITE;
                end
            end
            WRITE: begin
                we = bus.step;
                wd = exp_bit;
                if (bus.step) begin
                    addr_n = addr + 1'b1;
                    if (last) state_n = READ;
                end
            end
            READ: begin
                if (bus.step) begin
                    addr_n = addr + 1'b1;
                    if (bus.ram_q != exp_bit) begin
                        if (err != '1) err_n = err + 1'b1;
                        if (!seen) begin
                            fe_addr_n = addr;
                            fe_pass_n = ph;
                            seen_n    = 1'b1;
                        end
                    end
                    // End of a read sweep: second pass of writes, or finish.
                    if (last) begin
                        if (ph) begin
                            state_n = DONE;
                        end else begin
                            state_n = WRITE;
                            ph_n    = 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.ram_a          = addr;
    assign bus.ram_we         = we;
    assign bus.ram_d          = wd;
    assign bus.busy           = (state == CLEAR) || (state == WRITE) || (state == READ);
    assign bus.done           = (state == DONE);
    assign bus.pass           = (state == DONE) && (err == '0);
    assign bus.err_cnt        = err;
    assign bus.first_err_addr = fe_addr;
    assign bus.first_err_pass = fe_pass;
endmodule

// File: tb/tb_lutram_march_ctrl.sv
// Bench for lutram_march_ctrl: behavioural LUTRAM with injectable read faults
// and a pass/address-level reference of expected error results.
module tb_lutram_march_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic step = 1'b0;
    logic start = 1'b0;
    int   fault_mode = 0;      // 0 good, 1 stuck bit at fault_addr, 2 stuck output
    int   fault_addr = 0;
    logic fault_val = 1'b0;
    logic mem1 [64];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    lutram_march_if #(.A_WIDTH(6), .ERR_W(8)) b1 ();
    lutram_march_if #(.A_WIDTH(6), .ERR_W(4)) b2 ();

    lutram_march_ctrl #(.A_WIDTH(6), .ERR_W(8)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    lutram_march_ctrl #(.A_WIDTH(6), .ERR_W(4)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    assign b1.step  = step;
    assign b1.start = start;
    assign b2.step  = step;
    assign b2.start = start;
    assign b2.ram_q = 1'b1;
    assign b1.ram_q = (fault_mode == 2) ? fault_val :
                      ((fault_mode == 1) && (int'(b1.ram_a) == fault_addr)) ? fault_val :
                      mem1[b1.ram_a];

    always @(posedge clk) if (b1.ram_we) mem1[b1.ram_a] <= b1.ram_d;

    function automatic void ref_model(input int fm, input int fa, input logic fv,
                                      output int e, output int fea, output int fep);
        e = 0; fea = 0; fep = 0;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < 64; a++) begin
                logic expv, got;
                expv = ((a % 2) != p);
                got  = (fm == 2) ? fv : ((fm == 1) && (a == fa)) ? fv : expv;
                if (got != expv) begin
                    if (e == 0) begin fea = a; fep = p; end
                    e++;
                end
            end
        end
    endfunction

    // mode 0: step every cycle, 1: every 4th cycle, 2: random
    task automatic do_run(input int mode, input int restart_at,
                          output int busy_cyc, output int we_cyc, output int steps,
                          output int bad_we, output bit timeout);
        int k;
        busy_cyc = 0; we_cyc = 0; steps = 0; bad_we = 0; k = 0;
        @(negedge clk); start = 1'b1; step = 1'b0;
        @(negedge clk); start = 1'b0;
        while (!b1.done && k < 20000) begin
            step  = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 4 == 3) : ($urandom_range(0, 2) != 0);
            start = (k == restart_at);
            #1;
            if (b1.busy) busy_cyc++;
            if (b1.ram_we) we_cyc++;
            if (b1.ram_we && !step) bad_we++;
            if (b1.busy && step) steps++;
            k++;
            @(negedge clk);
        end
        step = 1'b0; start = 1'b0;
        timeout = !b1.done;
        n_checks++;
        if (timeout) begin n_fail++; $display("FAIL run_timeout: done=%0b want 1", b1.done); end
    endtask

    task automatic check_results(input string tag);
        int e, fea, fep;
        ref_model(fault_mode, fault_addr, fault_val, e, fea, fep);
        n_checks++;
        if (b1.err_cnt !== 8'(e)) begin n_fail++; $display("FAIL %s err_cnt: got %0d want %0d", tag, b1.err_cnt, e); end
        n_checks++;
        if (b1.first_err_addr !== 6'(fea)) begin n_fail++; $display("FAIL %s first_err_addr: got %0d want %0d", tag, b1.first_err_addr, fea); end
        n_checks++;
        if (b1.first_err_pass !== 1'(fep)) begin n_fail++; $display("FAIL %s first_err_pass: got %0d want %0d", tag, b1.first_err_pass, fep); end
        n_checks++;
        if (b1.pass !== (e == 0) || b1.done !== 1'b1 || b1.busy !== 1'b0) begin
            n_fail++; $display("FAIL %s status: pass=%0b done=%0b busy=%0b want pass=%0b done=1 busy=0", tag, b1.pass, b1.done, b1.busy, e == 0);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; step = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({b1.busy, b1.done, b1.pass, b1.err_cnt, b1.first_err_addr, b1.first_err_pass, b1.ram_a, b1.ram_d, b1.ram_we} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: busy=%0b done=%0b pass=%0b err=%0d a=%0d we=%0b want all 0", b1.busy, b1.done, b1.pass, b1.err_cnt, b1.ram_a, b1.ram_we);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (b1.busy !== 1'b0 || b1.ram_we !== 1'b0) begin n_fail++; $display("FAIL idle_no_start: busy=%0b we=%0b want 0 0", b1.busy, b1.ram_we); end
        step = 1'b0;
    endtask

    task automatic test_good_ram;
        int bc, wc, st, bw, bad_mem; bit to;
        fault_mode = 0;
        do_run(0, -1, bc, wc, st, bw, to);
        n_checks++;
        if (bc !== 320) begin n_fail++; $display("FAIL good_busy_cycles: got %0d want 320", bc); end
        check_results("good");
        bad_mem = 0;
        for (int a = 0; a < 64; a++) if (mem1[a] !== ((a % 2) == 0)) bad_mem++;
        n_checks++;
        if (bad_mem != 0) begin n_fail++; $display("FAIL good_final_mem: %0d bad cells want 0", bad_mem); end
        // results must hold in DONE while step toggles
        repeat (10) begin @(negedge clk); step = $urandom_range(0, 1); end
        #1;
        check_results("good_hold");
        step = 1'b0;
    endtask

    task automatic test_stuck0;
        int bc, wc, st, bw; bit to;
        fault_mode = 1; fault_addr = 5; fault_val = 1'b0;
        do_run(0, -1, bc, wc, st, bw, to);
        check_results("stuck0_a5");
    endtask

    task automatic test_stuck1_out;
        int bc, wc, st, bw; bit to;
        fault_mode = 2; fault_val = 1'b1;
        do_run(0, -1, bc, wc, st, bw, to);
        check_results("stuck1_out");
        n_checks++;
        if (b2.err_cnt !== 4'd15 || b2.pass !== 1'b0 || b2.done !== 1'b1) begin
            n_fail++; $display("FAIL sat_err4: err=%0d pass=%0b done=%0b want 15 0 1", b2.err_cnt, b2.pass, b2.done);
        end
    endtask

    task automatic test_slow_step;
        int bc, wc, st, bw; bit to;
        fault_mode = 0;
        do_run(1, -1, bc, wc, st, bw, to);
        n_checks++;
        if (bc !== 1280) begin n_fail++; $display("FAIL slow_busy_cycles: got %0d want 1280", bc); end
        n_checks++;
        if (wc !== 192 || bw !== 0) begin n_fail++; $display("FAIL slow_writes: we_cycles=%0d ungated=%0d want 192 0", wc, bw); end
        check_results("slow");
    endtask

    task automatic test_mid_reset;
        int bc, wc, st, bw; bit to;
        fault_mode = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; step = 1'b1;
        repeat (100) @(negedge clk);
        n_checks++;
        if (b1.busy !== 1'b1 || b1.ram_we !== 1'b1 || b1.ram_a !== 6'd36) begin
            n_fail++; $display("FAIL step100_write: busy=%0b we=%0b a=%0d want 1 1 36", b1.busy, b1.ram_we, b1.ram_a);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (b1.busy !== 1'b0 || b1.ram_we !== 1'b0 || b1.done !== 1'b0 || b1.err_cnt !== 8'd0 || b1.ram_a !== 6'd0) begin
            n_fail++; $display("FAIL mid_reset: busy=%0b we=%0b done=%0b err=%0d a=%0d want 0 0 0 0 0", b1.busy, b1.ram_we, b1.done, b1.err_cnt, b1.ram_a);
        end
        rst = 1'b0; step = 1'b0;
        // restart request during busy must not restart the sequence
        fault_mode = 2; fault_val = 1'b1;
        do_run(0, 150, bc, wc, st, bw, to);
        n_checks++;
        if (bc !== 320) begin n_fail++; $display("FAIL start_ignored_busy: busy_cycles=%0d want 320", bc); end
        check_results("restart_faulty");
        fault_mode = 0;
        do_run(0, -1, bc, wc, st, bw, to);
        check_results("restart_clean");
    endtask

    task automatic test_random;
        int bc, wc, st, bw; bit to;
        for (int i = 0; i < 5; i++) begin
            fault_mode = $urandom_range(0, 2);
            fault_addr = $urandom_range(0, 63);
            fault_val  = 1'($urandom_range(0, 1));
            do_run(2, -1, bc, wc, st, bw, to);
            n_checks++;
            if (st !== 320 || wc !== 192 || bw !== 0) begin
                n_fail++; $display("FAIL rand%0d_steps: steps=%0d writes=%0d ungated=%0d want 320 192 0", i, st, wc, bw);
            end
            check_results($sformatf("rand%0d_m%0d_a%0d_v%0d", i, fault_mode, fault_addr, fault_val));
        end
    endtask

    initial begin
        test_reset();
        test_good_ram();
        test_stuck0();
        test_stuck1_out();
        test_slow_step();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
